// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one Sysbus port between instruction fetch (ic_*) and data cache
// (dc_*). The bus is held for a whole transaction: address beat, then write data or read beats.
module sysbus_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      ic_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] ic_req,
  input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
  output logic                      ic_reqack,
  output logic                      ic_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] ic_resp,
  output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
  input  logic                      ic_respack,

  input  logic                      dc_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] dc_req,
  input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
  output logic                      dc_reqack,
  output logic                      dc_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] dc_resp,
  output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
  input  logic                      dc_respack,

  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int unsigned CntW = $clog2(BEATS) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAddr  = 2'd1;
  localparam logic [1:0] StWdata = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            owner_q, owner_d;  // 0 = ic, 1 = dc
  logic            rr_q, rr_d;        // requester favoured on the next tie
  logic [CntW-1:0] count_q, count_d;

  logic                      own_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] own_req;
  logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
  logic                      own_respack;
  logic                      last_beat;
  logic                      req_fwd;
  logic                      resp_fwd;

  assign own_reqcyc  = owner_q ? dc_reqcyc  : ic_reqcyc;
  assign own_req     = owner_q ? dc_req     : ic_req;
  assign own_reqtag  = owner_q ? dc_reqtag  : ic_reqtag;
  assign own_respack = owner_q ? dc_respack : ic_respack;
  assign last_beat   = (count_q == CntW'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (ic_reqcyc || dc_reqcyc) begin
          owner_d = (ic_reqcyc && dc_reqcyc) ? rr_q : dc_reqcyc;
          rr_d    = ~owner_d;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (bus_reqack) begin
          count_d = '0;
          state_d = own_reqtag[BUS_TAG_WIDTH-1] ? StWdata : StResp;
        end
      end
      StWdata: begin
        if (own_reqcyc && bus_reqack) begin
          count_d = count_q + 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      StResp: begin
        if (bus_respcyc && own_respack) begin
          count_d = count_q + 1'b1;
          if (last_beat) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Everything facing a client or the bus is decoded from state, so reset zeroes it at once.
  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    req_fwd     = 1'b0;
    resp_fwd    = 1'b0;
    unique case (state_q)
      StAddr: begin
        bus_reqcyc = 1'b1;
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        req_fwd    = bus_reqack;
      end
      StWdata: begin
        bus_reqcyc = own_reqcyc;
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        req_fwd    = bus_reqack;
      end
      StResp: begin
        bus_respack = own_respack;
        resp_fwd    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ic_reqack  = req_fwd & ~owner_q;
  assign dc_reqack  = req_fwd & owner_q;
  assign ic_respcyc = resp_fwd & ~owner_q & bus_respcyc;
  assign dc_respcyc = resp_fwd & owner_q & bus_respcyc;
  assign ic_resp    = (resp_fwd && !owner_q) ? bus_resp    : '0;
  assign ic_resptag = (resp_fwd && !owner_q) ? bus_resptag : '0;
  assign dc_resp    = (resp_fwd && owner_q)  ? bus_resp    : '0;
  assign dc_resptag = (resp_fwd && owner_q)  ? bus_resptag : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: directed reset/stray/tie cases, then randomized rounds checked by a
// scoreboard fed from a transaction-level model of grant order and beat contents.
module tb_sysbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_reqcyc, ic_reqack, ic_respcyc, ic_respack;
  logic [63:0] ic_req, ic_resp;
  logic [12:0] ic_reqtag, ic_resptag;
  logic        dc_reqcyc, dc_reqack, dc_respcyc, dc_respack;
  logic [63:0] dc_req, dc_resp;
  logic [12:0] dc_reqtag, dc_resptag;
  logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0] bus_req, bus_resp;
  logic [12:0] bus_reqtag, bus_resptag;
  logic        stray = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          c;
    logic [63:0] data;
    logic [12:0] tag;
  } beat_t;

  beat_t exp_bus_q[$];
  beat_t exp_ic_q[$];
  beat_t exp_dc_q[$];

  sysbus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .ic_reqcyc   (ic_reqcyc),
    .ic_req      (ic_req),
    .ic_reqtag   (ic_reqtag),
    .ic_reqack   (ic_reqack),
    .ic_respcyc  (ic_respcyc),
    .ic_resp     (ic_resp),
    .ic_resptag  (ic_resptag),
    .ic_respack  (ic_respack),
    .dc_reqcyc   (dc_reqcyc),
    .dc_req      (dc_req),
    .dc_reqtag   (dc_reqtag),
    .dc_reqack   (dc_reqack),
    .dc_respcyc  (dc_respcyc),
    .dc_resp     (dc_resp),
    .dc_resptag  (dc_resptag),
    .dc_respack  (dc_respack),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic any_out();
    return |{ic_reqack, ic_respcyc, ic_resp, ic_resptag, dc_reqack, dc_respcyc, dc_resp,
             dc_resptag, bus_reqcyc, bus_req, bus_reqtag, bus_respack};
  endfunction

  function automatic logic [63:0] wdata(input logic [63:0] addr, input int i);
    return ~addr + 64'(i) * 64'h0001_0000_0000_0001;
  endfunction

  function automatic logic [63:0] rdata(input logic [63:0] addr, input int i);
    return {addr[31:0] ^ 32'hC0DE_0000, 32'(i) * 32'h0101_0101};
  endfunction

  // Transaction-level expectations: one address beat, then 8 write beats on the bus or
  // 8 read beats delivered to the requester.
  task automatic push_txn(input int c, input logic [63:0] addr, input logic [12:0] tag);
    beat_t b;
    b.c = c; b.tag = tag; b.data = addr;
    exp_bus_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      if (tag[12]) begin
        b.data = wdata(addr, i);
        exp_bus_q.push_back(b);
      end else begin
        b.data = rdata(addr, i);
        if (c == 0) exp_ic_q.push_back(b);
        else exp_dc_q.push_back(b);
      end
    end
  endtask

  task automatic drive_req(input int c, input logic cyc, input logic [63:0] d,
                           input logic [12:0] t);
    if (c == 0) begin
      ic_reqcyc = cyc; ic_req = d; ic_reqtag = t;
    end else begin
      dc_reqcyc = cyc; dc_req = d; dc_reqtag = t;
    end
  endtask

  task automatic run_client(input int c, input logic [63:0] addr, input logic [12:0] tag);
    int nb;
    int waited;
    logic acked;
    logic abort;
    nb = tag[12] ? 9 : 1;
    abort = 1'b0;
    for (int b = 0; b < nb && !abort; b++) begin
      drive_req(c, 1'b1, (b == 0) ? addr : wdata(addr, b - 1), tag);
      acked = 1'b0;
      waited = 0;
      while (!acked && !abort) begin
        @(negedge clk);
        acked = (c == 0) ? ic_reqack : dc_reqack;
        @(posedge clk);
        #1;
        waited++;
        if (waited > 300) begin
          fail_now("req_ack_timeout");
          abort = 1'b1;
        end
      end
    end
    drive_req(c, 1'b0, '0, '0);
  endtask

  // Sysbus slave: random acks, 8 read beats with random gaps, stray beats when nothing is due.
  task automatic slave();
    int wleft = 0;
    int rleft = 0;
    int ridx = 0;
    logic [63:0] raddr = '0;
    logic [12:0] rtag = '0;
    forever begin
      @(negedge clk);
      if (bus_reqcyc && bus_reqack) begin
        if (wleft > 0) wleft--;
        else if (bus_reqtag[12]) wleft = 8;
        else begin
          rleft = 8; ridx = 0; raddr = bus_req; rtag = bus_reqtag;
        end
      end
      if (bus_respcyc && bus_respack && !stray) begin
        ridx++;
        rleft--;
      end
      @(posedge clk);
      #1;
      bus_reqack = ($urandom % 3) != 0;
      stray = 1'b0;
      if (rleft > 0) begin
        bus_respcyc = ($urandom % 4) != 0;
        bus_resp    = rdata(raddr, ridx);
        bus_resptag = rtag;
      end else if (($urandom % 8) == 0) begin
        bus_respcyc = 1'b1;
        stray       = 1'b1;
        bus_resp    = {$urandom, $urandom};
        bus_resptag = 13'($urandom);
      end else begin
        bus_respcyc = 1'b0;
      end
    end
  endtask

  task automatic resp_driver();
    forever begin
      @(posedge clk);
      #1;
      ic_respack = ($urandom % 4) != 0;
      dc_respack = ($urandom % 4) != 0;
    end
  endtask

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (bus_reqcyc && bus_reqack) begin
        if (exp_bus_q.size() == 0) fail_now("bus_beat_unexpected");
        else begin
          e = exp_bus_q.pop_front();
          chk("bus_req", bus_req, e.data);
          chk("bus_reqtag", 64'(bus_reqtag), 64'(e.tag));
          chk("reqack_owner", 64'({ic_reqack, dc_reqack}), (e.c == 0) ? 64'd2 : 64'd1);
        end
      end
      if (ic_respcyc && ic_respack) begin
        if (exp_ic_q.size() == 0) fail_now("ic_resp_unexpected");
        else begin
          e = exp_ic_q.pop_front();
          chk("ic_resp", ic_resp, e.data);
          chk("ic_resptag", 64'(ic_resptag), 64'(e.tag));
        end
      end
      if (dc_respcyc && dc_respack) begin
        if (exp_dc_q.size() == 0) fail_now("dc_resp_unexpected");
        else begin
          e = exp_dc_q.pop_front();
          chk("dc_resp", dc_resp, e.data);
          chk("dc_resptag", 64'(dc_resptag), 64'(e.tag));
        end
      end
      if (ic_respcyc) chk("ic_respack_fwd", 64'(bus_respack), 64'(ic_respack));
      if (dc_respcyc) chk("dc_respack_fwd", 64'(bus_respack), 64'(dc_respack));
      if (stray) chk("stray_blocked", 64'({bus_respack, ic_respcyc, dc_respcyc}), 64'd0);
    end
  endtask

  task automatic latency_check();
    @(negedge clk);
    chk("idle_no_reqcyc", 64'(bus_reqcyc), 64'd0);
    @(negedge clk);
    chk("grant_latency", 64'(bus_reqcyc), 64'd1);
  endtask

  int          mode;
  int          first;
  int          rr_model;
  logic        use_ic, use_dc, drained;
  logic [63:0] ic_addr, dc_addr;
  logic [12:0] ic_tag, dc_tag;

  initial begin
    reset = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    ic_respack = 1'b0; dc_respack = 1'b0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    #3;
    chk("reset_outputs", 64'(any_out()), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Stray response beat while idle.
    @(posedge clk);
    #1;
    bus_respcyc = 1'b1; bus_resp = 64'hBAD0; bus_resptag = 13'h55;
    ic_respack = 1'b1; dc_respack = 1'b1;
    #1;
    chk("stray_respack", 64'(bus_respack), 64'd0);
    chk("stray_client", 64'({ic_respcyc, dc_respcyc}), 64'd0);
    @(posedge clk);
    #1 bus_respcyc = 1'b0; ic_respack = 1'b0; dc_respack = 1'b0;

    // Read by fetch, then reset while beat 3 is on the bus.
    drive_req(0, 1'b1, 64'h1000, 13'h0012);
    @(posedge clk);
    #1 bus_reqack = 1'b1;
    #1;
    chk("addr_bus_req", bus_req, 64'h1000);
    chk("addr_ic_reqack", 64'({bus_reqcyc, ic_reqack, dc_reqack}), 64'd6);
    @(posedge clk);
    #1;
    drive_req(0, 1'b0, '0, '0);
    bus_reqack = 1'b0; ic_respack = 1'b1; bus_respcyc = 1'b1; bus_resptag = 13'h0012;
    for (int i = 0; i < 3; i++) begin
      bus_resp = 64'(i);
      #1;
      chk("dir_ic_resp", ic_resp, 64'(i));
      chk("dir_resp_flags", 64'({ic_respcyc, dc_respcyc, bus_respack}), 64'd5);
      @(posedge clk);
      #1;
    end
    bus_resp = 64'd3;
    reset = 1'b0;
    #1;
    chk("reset_mid_resp", 64'(any_out()), 64'd0);
    @(posedge clk);
    #1 bus_respcyc = 1'b0; ic_respack = 1'b0; reset = 1'b1;

    // Tie straight after reset goes to fetch.
    @(posedge clk);
    #1;
    drive_req(0, 1'b1, 64'hA000, 13'h0001);
    drive_req(1, 1'b1, 64'hB000, 13'h0002);
    @(posedge clk);
    #1;
    chk("tie_ic_first", bus_req, 64'hA000);
    reset = 1'b0;
    drive_req(0, 1'b0, '0, '0);
    drive_req(1, 1'b0, '0, '0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Randomized rounds against the scoreboard.
    rr_model = 0;
    fork
      slave();
      resp_driver();
      monitor();
    join_none
    @(posedge clk);
    #1;
    for (int r = 0; r < 40; r++) begin
      mode   = $urandom_range(1, 3);
      use_ic = (mode != 2);
      use_dc = (mode != 1);
      ic_addr = 64'h1_0000_0000 | 64'($urandom & 32'hFFFF_FFC0);
      dc_addr = 64'h2_0000_0000 | 64'($urandom & 32'hFFFF_FFC0);
      ic_tag  = {1'b0, 12'($urandom)};
      dc_tag  = {1'($urandom), 12'($urandom)};
      first   = (use_ic && use_dc) ? rr_model : (use_dc ? 1 : 0);
      push_txn(first, (first == 0) ? ic_addr : dc_addr, (first == 0) ? ic_tag : dc_tag);
      if (use_ic && use_dc) begin
        push_txn(1 - first, (first == 0) ? dc_addr : ic_addr, (first == 0) ? dc_tag : ic_tag);
        rr_model = first;
      end else begin
        rr_model = 1 - first;
      end
      fork
        if (use_ic) run_client(0, ic_addr, ic_tag);
        if (use_dc) run_client(1, dc_addr, dc_tag);
        latency_check();
      join
      drained = 1'b0;
      for (int k = 0; k < 400 && !drained; k++) begin
        @(posedge clk);
        drained = (exp_bus_q.size() + exp_ic_q.size() + exp_dc_q.size()) == 0;
      end
      #1;
      if (!drained) begin
        fail_now("drain_timeout");
        exp_bus_q.delete(); exp_ic_q.delete(); exp_dc_q.delete();
      end
    end
    repeat (4) @(posedge clk);
    chk("queues_drained", 64'(exp_bus_q.size() + exp_ic_q.size() + exp_dc_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
